log2_calc: RTL and testbench

Iterative runtime ceil(log2(n)) / bit-width calculator: the sequential, parametrised successor to the elaboration-time `clog2`/`bits` functions in `common`. It serves datapaths that size or address things from run-time values, such as DMA burst lengths or FIFO fill levels. A valid/ready request is accepted, reduced STEP bits per cycle, and returned as `clog2`, `bits` and a power-of-two flag on a valid/ready result port. The results match `common::clog2`/`common::bits` bit-exactly for every W-bit unsigned input.

---
 rtl/common.sv | 32 +++
 rtl/log2_calc_pkg.sv | 13 +
 rtl/log2_calc_msb.sv | 20 ++
 rtl/log2_calc.sv | 157 +++++++++++++++
 tb/tb_log2_calc.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/common.sv
// common: shared elaboration-time helpers (clog2, bits, max).
// These are the reference definitions the runtime log2_calc block reproduces.
package common;

    // Smallest c with 2**c >= n; 0 for n = 0 and n = 1.
    function automatic int clog2(input longint unsigned n);
        int              r;
        longint unsigned v;
        r = 0;
        v = (n == 64'd0) ? 64'd0 : n - 64'd1;
        for (int i = 0; i < 64; i++) begin
            if (v[i]) r = i + 1;
        end
        return r;
    endfunction

    // Number of bits needed to hold n; 0 for n = 0.
    function automatic int bits(input longint unsigned n);
        int r;
        r = 0;
        for (int i = 0; i < 64; i++) begin
            if (n[i]) r = i + 1;
        end
        return r;
    endfunction

    // Larger of two integers.
    function automatic int max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/log2_calc_pkg.sv
// log2_calc_pkg: FSM state type and width limit shared by the log2_calc block.
package log2_calc_pkg;

    // Operand width ceiling supported by the calculator.
    localparam int LOG2_CALC_W_MAX = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } log2_calc_state_t;

endpackage

// File: rtl/log2_calc_msb.sv
// log2_calc_msb: combinational STEP-bit priority encoder.
// Returns the index of the highest set bit of vec (0 when vec is zero;
// callers only use the index for a nonzero vec).
module log2_calc_msb #(
    parameter int STEP = 1,
    parameter int OW   = 1
) (
    input  logic [STEP-1:0] vec,
    output logic [OW-1:0]   idx
);

    // Scan upward so the highest set bit is the last one to write idx
    always_comb begin
        idx = '0;
        for (int i = 0; i < STEP; i++) begin
            if (vec[i]) idx = OW'(i);
        end
    end

endmodule

// File: rtl/log2_calc.sv
// log2_calc: iterative runtime ceil(log2(n)) / bit-width calculator.
//
// A request n is accepted on the input valid/ready port, reduced STEP bits
// per cycle, and the result (clog2, bits, pow2, zero) is returned on the
// output valid/ready port. Only one request is in flight at a time.
//
// Handshake rule for both ports: a transfer happens on a rising clk edge
// where valid and ready are both 1; valid, once raised, is held with its
// payload unchanged until that transfer; ready may be raised independently.
//
// Optional feature: define LOG2_CALC_MAX_TRACK_EN to add the max_clr input
// and the max_bits output (running maximum of delivered out_bits).
module log2_calc
    import log2_calc_pkg::*;
#(
    parameter  int W    = 32,
    parameter  int STEP = 1,
    localparam int RW   = common::bits(longint'(W))
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RW-1:0]    out_clog2,
    output logic [RW-1:0]    out_bits,
    output logic             out_pow2,
    output logic             out_zero,
    output log2_calc_state_t dbg_state
`ifdef LOG2_CALC_MAX_TRACK_EN
    ,
    input  logic             max_clr,
    output logic [RW-1:0]    max_bits
`endif
);

    // Parameter range guards
    if (W < 2 || W > LOG2_CALC_W_MAX) begin : g_bad_w
        $error("log2_calc: W must be in 2..%0d", LOG2_CALC_W_MAX);
    end
    if (STEP < 1 || STEP > W) begin : g_bad_step
        $error("log2_calc: STEP must be in 1..W");
    end

    log2_calc_state_t state;

    // Remaining value still to be measured, and the bit count retired so far
    logic [W-1:0]  num;
    logic [RW-1:0] res;
    // Classification of the accepted operand, carried to the result
    logic          pow2_q;
    logic          zero_q;

    // num with the current STEP-bit digit removed
    logic [W-1:0]  num_hi;
    // Highest set bit inside the lowest STEP-bit digit of num
    logic [RW-1:0] msb_idx;

    if (STEP >= W) begin : g_hi_full
        assign num_hi = '0;
    end else begin : g_hi_shift
        assign num_hi = num >> STEP;
    end

    log2_calc_msb #(
        .STEP (STEP),
        .OW   (RW)
    ) u_msb (
        .vec (num[STEP-1:0]),
        .idx (msb_idx)
    );

    assign dbg_state = state;

    // Control FSM with registered handshake flags and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            num       <= '0;
            res       <= '0;
            pow2_q    <= 1'b0;
            zero_q    <= 1'b0;
            out_clog2 <= '0;
            out_bits  <= '0;
            out_pow2  <= 1'b0;
            out_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        // ceil(log2(n)) is the bit length of n-1; n = 0 is
                        // pinned to 0 so it does not wrap to all-ones.
                        num      <= (in_data == '0) ? '0 : in_data - W'(1);
                        res      <= '0;
                        pow2_q   <= (in_data != '0) &&
                                    ((in_data & (in_data - W'(1))) == '0);
                        zero_q   <= (in_data == '0);
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    if (num == '0) begin
                        state <= DONE;
                    end else if (num_hi == '0) begin
                        // Last digit: count only up to its highest set bit
                        res   <= res + msb_idx + RW'(1);
                        state <= DONE;
                    end else begin
                        num <= num_hi;
                        res <= res + RW'(STEP);
                    end
                end
                DONE: begin
                    if (!out_valid) begin
                        // Publish the result; it then stays frozen until taken
                        out_valid <= 1'b1;
                        out_clog2 <= res;
                        out_bits  <= res + RW'(pow2_q);
                        out_pow2  <= pow2_q;
                        out_zero  <= zero_q;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef LOG2_CALC_MAX_TRACK_EN
    // Running maximum of delivered widths; a delivery outranks a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_bits <= '0;
        end else if (out_valid && out_ready) begin
            if (max_clr) begin
                max_bits <= out_bits;
            end else begin
                max_bits <= RW'(common::max(int'(max_bits), int'(out_bits)));
            end
        end else if (max_clr) begin
            max_bits <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_log2_calc.sv
// tb_log2_calc: self-checking bench for log2_calc.
// Three instances share clk/rst: W=32/STEP=1, W=32/STEP=4, W=16/STEP=16.
// Build with LOG2_CALC_MAX_TRACK_EN defined to also exercise max_bits.
module tb_log2_calc;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic        in_valid[3];
    logic        out_ready[3];
    logic [31:0] in_data[3];

    logic       rdy0, vld0, p20, z0;
    logic [5:0] c20, b0;
    logic       rdy1, vld1, p21, z1;
    logic [5:0] c21, b1;
    logic       rdy2, vld2, p22, z2;
    logic [4:0] c22, b2;
    log2_calc_pkg::log2_calc_state_t st0, st1, st2;

`ifdef LOG2_CALC_MAX_TRACK_EN
    logic       max_clr0;
    logic [5:0] max0, max1;
    logic [4:0] max2;
`endif

    // Uniform views of the three instances
    logic       s_ready[3], s_valid[3], s_pow2[3], s_zero[3];
    logic [6:0] s_c2[3], s_bits[3];

    always_comb begin
        s_ready[0] = rdy0; s_valid[0] = vld0; s_pow2[0] = p20; s_zero[0] = z0;
        s_c2[0] = 7'(c20); s_bits[0] = 7'(b0);
        s_ready[1] = rdy1; s_valid[1] = vld1; s_pow2[1] = p21; s_zero[1] = z1;
        s_c2[1] = 7'(c21); s_bits[1] = 7'(b1);
        s_ready[2] = rdy2; s_valid[2] = vld2; s_pow2[2] = p22; s_zero[2] = z2;
        s_c2[2] = 7'(c22); s_bits[2] = 7'(b2);
    end

    log2_calc #(.W(32), .STEP(1)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(rdy0),
        .in_data(in_data[0]), .out_valid(vld0), .out_ready(out_ready[0]),
        .out_clog2(c20), .out_bits(b0), .out_pow2(p20), .out_zero(z0),
        .dbg_state(st0)
`ifdef LOG2_CALC_MAX_TRACK_EN
        , .max_clr(max_clr0), .max_bits(max0)
`endif
    );

    log2_calc #(.W(32), .STEP(4)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(rdy1),
        .in_data(in_data[1]), .out_valid(vld1), .out_ready(out_ready[1]),
        .out_clog2(c21), .out_bits(b1), .out_pow2(p21), .out_zero(z1),
        .dbg_state(st1)
`ifdef LOG2_CALC_MAX_TRACK_EN
        , .max_clr(1'b0), .max_bits(max1)
`endif
    );

    log2_calc #(.W(16), .STEP(16)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(rdy2),
        .in_data(in_data[2][15:0]), .out_valid(vld2), .out_ready(out_ready[2]),
        .out_clog2(c22), .out_bits(b2), .out_pow2(p22), .out_zero(z2),
        .dbg_state(st2)
`ifdef LOG2_CALC_MAX_TRACK_EN
        , .max_clr(1'b0), .max_bits(max2)
`endif
    );

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic [1:0]  d;
        logic [6:0]  c2;
        logic [6:0]  bits;
        logic        p2;
        logic        z;
        logic [31:0] due;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_cur;
    exp_t e_new;

    int checks      = 0;
    int failures    = 0;
    int skip_ready  = 1;
    int last_in_hs  = 0;
    int last_out_hs = 0;

    // Expectation for the next accepted request
    logic [6:0] pend_c2, pend_bits;
    logic       pend_p2, pend_z;
    int         pend_lat;

    int step_of[3] = '{1, 4, 16};

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int ref_clog2(input longint unsigned n);
        int c = 0;
        while (c < 64 && (64'd1 << c) < n) c++;
        return c;
    endfunction

    function automatic int ref_bits(input longint unsigned n);
        int c = 0;
        while (c < 64 && (n >> c) != 64'd0) c++;
        return c;
    endfunction

    // Cycles from input handshake to out_valid: 1 + max(1, ceil(L/STEP))
    function automatic int ref_lat(input longint unsigned n, input int step);
        longint unsigned m;
        int l, k;
        m = (n == 64'd0) ? 64'd0 : n - 64'd1;
        l = ref_bits(m);
        k = (l + step - 1) / step;
        if (k < 1) k = 1;
        return 1 + k;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (rst) begin
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("rst_valid%0d", d), s_valid[d], 0);
                chk($sformatf("rst_ready%0d", d), s_ready[d], 0);
                chk($sformatf("rst_clog2_%0d", d), s_c2[d], 0);
                chk($sformatf("rst_bits%0d", d), s_bits[d], 0);
                chk($sformatf("rst_pow2_%0d", d), s_pow2[d], 0);
                chk($sformatf("rst_zero%0d", d), s_zero[d], 0);
            end
`ifdef LOG2_CALC_MAX_TRACK_EN
            chk("rst_max0", max0, 0);
            chk("rst_max1", max1, 0);
            chk("rst_max2", max2, 0);
`endif
            exp_q.delete();
            skip_ready = 1;
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (exp_q.size() != 0 && int'(exp_q[0].d) == d) begin
                    e_cur = exp_q[0];
                    chk($sformatf("busy_ready%0d", d), s_ready[d], 0);
                    if (cyc < int'(e_cur.due)) begin
                        chk($sformatf("early_valid%0d", d), s_valid[d], 0);
                    end else begin
                        chk($sformatf("out_valid%0d", d), s_valid[d], 1);
                        chk($sformatf("out_clog2_%0d", d), s_c2[d], e_cur.c2);
                        chk($sformatf("out_bits%0d", d), s_bits[d], e_cur.bits);
                        chk($sformatf("out_pow2_%0d", d), s_pow2[d], e_cur.p2);
                        chk($sformatf("out_zero%0d", d), s_zero[d], e_cur.z);
                        if (s_valid[d] && out_ready[d]) begin
                            void'(exp_q.pop_front());
                            last_out_hs = cyc + 1;
                        end
                    end
                end else begin
                    chk($sformatf("idle_valid%0d", d), s_valid[d], 0);
                    if (skip_ready == 0) chk($sformatf("idle_ready%0d", d), s_ready[d], 1);
                    if (in_valid[d] && s_ready[d]) begin
                        e_new.d    = 2'(d);
                        e_new.c2   = pend_c2;
                        e_new.bits = pend_bits;
                        e_new.p2   = pend_p2;
                        e_new.z    = pend_z;
                        e_new.due  = 32'(cyc + 1 + pend_lat);
                        exp_q.push_back(e_new);
                        last_in_hs = cyc + 1;
                    end
                end
            end
            skip_ready = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_req(input int d, input logic [31:0] n, input int c2, input int b,
                            input int p2, input int z, input int lat);
        int t;
        pend_c2   = 7'(c2);
        pend_bits = 7'(b);
        pend_p2   = p2[0];
        pend_z    = z[0];
        pend_lat  = lat;
        @(posedge clk); #1;
        in_data[d]  = n;
        in_valid[d] = 1'b1;
        t = 0;
        while (t < 100) begin
            @(negedge clk);
            if (s_ready[d]) break;
            t++;
        end
        chk($sformatf("in_accept%0d", d), (t < 100), 1);
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("result_taken", (exp_q.size() == 0), 1);
        exp_q.delete();
    endtask

    task automatic send(input int d, input logic [31:0] n, input int c2, input int b,
                        input int p2, input int z, input int lat);
        push_req(d, n, c2, b, p2, z, lat);
        wait_done();
    endtask

    task automatic send_model(input int d, input logic [31:0] n);
        longint unsigned v;
        int c2, b, p2, z;
        v  = longint'(n);
        c2 = ref_clog2(v);
        b  = ref_bits(v);
        p2 = (v != 64'd0 && (64'd1 << c2) == v) ? 1 : 0;
        z  = (v == 64'd0) ? 1 : 0;
        send(d, n, c2, b, p2, z, ref_lat(v, step_of[d]));
    endtask

    task automatic wait_valid(input int d);
        int t = 0;
        while (t < 100) begin
            @(negedge clk);
            if (s_valid[d]) break;
            t++;
        end
        chk($sformatf("valid_seen%0d", d), (t < 100), 1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int t;
        logic [31:0] r;
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b1;
            in_data[d]   = '0;
        end
        pend_c2 = '0; pend_bits = '0; pend_p2 = 1'b0; pend_z = 1'b0; pend_lat = 0;
`ifdef LOG2_CALC_MAX_TRACK_EN
        max_clr0 = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Pin the model with hand-computed values
        chk("model_clog2_32", ref_clog2(32), 5);
        chk("model_bits_32", ref_bits(32), 6);
        chk("model_clog2_33", ref_clog2(33), 6);
        chk("model_clog2_max", ref_clog2(64'hFFFF_FFFF), 32);
        chk("model_lat_32_s1", ref_lat(32, 1), 6);
        chk("model_lat_max_s4", ref_lat(64'hFFFF_FFFF, 4), 9);

        // W=32 STEP=1 directed
        send(0, 32,  5, 6, 1, 0, 6);
        send(0, 33,  6, 6, 0, 0, 7);
        send(0, 0,   0, 0, 0, 1, 2);
        send(0, 1,   0, 1, 1, 0, 2);

        // W=32 STEP=4 directed
        send(1, 0,            0,  0, 0, 1, 2);
        send(1, 1,            0,  1, 1, 0, 2);
        send(1, 2,            1,  2, 1, 0, 2);
        send(1, 32'hFFFF_FFFF, 32, 32, 0, 0, 9);
        send(1, 32'h8000_0000, 31, 32, 1, 0, 9);

        // W=16 STEP=16 directed and sweep
        send(2, 32'h0000_FFFF, 16, 16, 0, 0, 2);
        send(2, 32'h0000_8000, 15, 16, 1, 0, 2);
        for (int n = 0; n <= 300; n++) send_model(2, 32'(n));
        for (int b = 0; b < 16; b++) begin
            send_model(2, 32'(1 << b));
            send_model(2, 32'((1 << b) + 1) & 32'h0000_FFFF);
            send_model(2, 32'((1 << b) - 1));
        end

        // Assorted operands through the model on the W=32 instances
        for (int i = 0; i < 8; i++) begin
            r = $urandom >> $urandom_range(0, 31);
            send_model(0, r);
            r = $urandom >> $urandom_range(0, 31);
            send_model(1, r);
        end

        // Backpressure: hold the result 10 cycles with a waiting request
        out_ready[1] = 1'b0;
        push_req(1, 100, 7, 7, 0, 0, 3);
        wait_valid(1);
        @(posedge clk); #1;
        pend_c2 = 7'd6; pend_bits = 7'd7; pend_p2 = 1'b1; pend_z = 1'b0; pend_lat = 3;
        in_data[1]  = 64;
        in_valid[1] = 1'b1;
        repeat (10) @(negedge clk);
        @(posedge clk); #1;
        out_ready[1] = 1'b1;
        t = 0;
        while (t < 50) begin
            @(negedge clk);
            if (s_ready[1]) break;
            t++;
        end
        chk("bp_accept", (t < 50), 1);
        @(posedge clk); #1;
        in_valid[1] = 1'b0;
        chk("bp_accept_gap", last_in_hs - last_out_hs, 1);
        wait_done();

        // Reset mid-CALC discards the in-flight result
        push_req(0, 32'h8000_0000, 31, 32, 1, 0, 32);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (40) @(negedge clk);
        send(0, 8, 3, 4, 1, 0, 4);

`ifdef LOG2_CALC_MAX_TRACK_EN
        // Running maximum of delivered widths
        send(0, 4, 2, 3, 1, 0, 3);
        @(negedge clk);
        chk("max_after_3", max0, 3);
        send(0, 100, 7, 7, 0, 0, 8);
        @(negedge clk);
        chk("max_after_7", max0, 7);
        send(0, 17, 5, 5, 0, 0, 6);
        @(negedge clk);
        chk("max_after_5", max0, 7);
        // Clear in the same cycle as a bits-2 delivery
        out_ready[0] = 1'b0;
        push_req(0, 3, 2, 2, 0, 0, 3);
        wait_valid(0);
        chk("max_hold", max0, 7);
        @(posedge clk); #1;
        max_clr0     = 1'b1;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        max_clr0 = 1'b0;
        @(negedge clk);
        chk("max_clr_with_hs", max0, 2);
        wait_done();
`endif

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
